// File: rtl/adder_pipe.sv
// Pipelined add/sub/accumulate unit with carry, signed-overflow and zero flags.
// Latency: result valid STAGES-1 cycles after the accepting edge; one beat per cycle unstalled.
// Backpressure: in_ready = !v[0] || stage 0 advancing, combinational from out_ready; no skid buffer.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      operand handshake; op, cin, A_in, B_in sampled on accept
//   op                     00 add, 01 sub (A-B-cin), 10 acc += A_in, 11 clear acc
//   out_valid/out_ready    result handshake; C_out, carry, ovf, zero held while stalled
module adder_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic                  cin,
  input  logic [DATA_WIDTH-1:0] A_in,
  input  logic [DATA_WIDTH-1:0] B_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] C_out,
  output logic                  carry,
  output logic                  ovf,
  output logic                  zero
);

  localparam int W   = DATA_WIDTH;
  localparam int MSB = DATA_WIDTH - 1;

  logic [STAGES-1:0] v;
  logic [W-1:0]      d_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] o_q;
  logic [STAGES-1:0] z_q;
  logic [STAGES-1:0] ld;
  logic [W-1:0]      acc;
  logic              accept;

  logic [W-1:0]      opa;
  logic [W-1:0]      opb;
  logic              ci;
  logic [W:0]        sum;
  logic [W-1:0]      res;
  logic              res_c;
  logic              res_o;
  logic              res_z;

  // True when every stage from k up to the output holds a beat.
  function automatic logic all_full_from(input logic [STAGES-1:0] vv, input int k);
    logic f;
    f = 1'b1;
    for (int j = 0; j < STAGES; j++) begin
      if (j >= k) f = f & vv[j];
    end
    return f;
  endfunction

  // Stage k can load unless it and every stage after it are full and the
  // consumer is stalling; this lets bubbles collapse under a stalled output.
  always_comb begin
    ld = '0;
    for (int k = 0; k < STAGES; k++) begin
      ld[k] = out_ready || !all_full_from(v, k);
    end
  end

  assign in_ready = ld[0];
  assign accept   = in_valid && in_ready;

  // One adder serves every op: sub is A + ~B + !cin, accumulate is acc + A_in,
  // and clear feeds zeros so the flags naturally come out 0/0/zero=1.
  always_comb begin
    opa = A_in;
    opb = B_in;
    ci  = cin;
    case (op)
      2'b01: begin
        opb = ~B_in;
        ci  = ~cin;
      end
      2'b10: begin
        opa = acc;
        opb = A_in;
        ci  = 1'b0;
      end
      2'b11: begin
        opa = '0;
        opb = '0;
        ci  = 1'b0;
      end
      default: ;
    endcase
    sum   = {1'b0, opa} + {1'b0, opb} + {{W{1'b0}}, ci};
    res   = sum[W-1:0];
    res_c = sum[W];
    res_o = (opa[MSB] == opb[MSB]) && (sum[MSB] != opa[MSB]);
    res_z = (res == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v   <= '0;
      c_q <= '0;
      o_q <= '0;
      z_q <= '0;
      acc <= '0;
      for (int k = 0; k < STAGES; k++) d_q[k] <= '0;
    end else begin
      // acc updates on the accepting edge so the next beat sees the new value.
      if (accept) begin
        if (op == 2'b10)      acc <= res;
        else if (op == 2'b11) acc <= '0;
      end

      if (ld[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          d_q[0] <= res;
          c_q[0] <= res_c;
          o_q[0] <= res_o;
          z_q[0] <= res_z;
        end
      end

      // Payload only moves with a valid beat, so a stalled output never changes.
      for (int k = 1; k < STAGES; k++) begin
        if (ld[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) begin
            d_q[k] <= d_q[k-1];
            c_q[k] <= c_q[k-1];
            o_q[k] <= o_q[k-1];
            z_q[k] <= z_q[k-1];
          end
        end
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign C_out     = d_q[STAGES-1];
  assign carry     = c_q[STAGES-1];
  assign ovf       = o_q[STAGES-1];
  assign zero      = z_q[STAGES-1];

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe with an arithmetic reference model.
// Latency: compares each popped result against a queue of modelled results.
// Backpressure: drives random valid/ready and checks hold-while-stalled.
module tb_adder_pipe;

  localparam int W = 16;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic         cin;
  logic [W-1:0] A_in;
  logic [W-1:0] B_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] C_out;
  logic         carry;
  logic         ovf;
  logic         zero;

  always #5 clk = ~clk;

  adder_pipe #(.DATA_WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .cin(cin), .A_in(A_in), .B_in(B_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .C_out(C_out), .carry(carry), .ovf(ovf), .zero(zero)
  );

  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           accepted = 0;
  int           pops = 0;
  logic [W+2:0] exp_q[$];
  int           acc_cyc_q[$];
  logic [W-1:0] acc_m;
  logic [W+2:0] last_pop;
  logic [W+2:0] held;
  logic         prev_stall;
  logic         lat_chk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic. carry = unsigned result fits in W+1
  // bits above 2^W (or no borrow for sub); ovf = signed result out of range.
  function automatic logic [W+2:0] model_apply(input logic [1:0] o, input logic ci,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
    int ua, ub, sa, sb, u, s, ci_i;
    logic [W-1:0] r;
    logic cy, ov;
    ci_i = ci ? 1 : 0;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    u = 0; s = 0; cy = 1'b0;
    case (o)
      2'b00: begin u = ua + ub + ci_i; s = sa + sb + ci_i; cy = (u >= (1 << W)); end
      2'b01: begin u = ua - ub - ci_i; s = sa - sb - ci_i; cy = (u >= 0); end
      2'b10: begin
        u = int'(acc_m) + ua;
        s = int'($signed(acc_m)) + sa;
        cy = (u >= (1 << W));
      end
      default: begin u = 0; s = 0; cy = 1'b0; end
    endcase
    r  = u[W-1:0];
    ov = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
    if (o == 2'b10) acc_m = r;
    if (o == 2'b11) acc_m = '0;
    return {r, cy, ov, (r == '0)};
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 time unit later.
  task automatic step(input logic iv, input logic [1:0] o, input logic ci,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
    int lat;
    @(negedge clk);
    in_valid = iv; op = o; cin = ci; A_in = a; B_in = b; out_ready = ordy;
    #1;
    if (prev_stall) begin
      check("stall_valid", out_valid, 1);
      check("stall_hold", {C_out, carry, ovf, zero}, held);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        last_pop = exp_q.pop_front();
        lat = cyc - acc_cyc_q.pop_front();
        check("result", {C_out, carry, ovf, zero}, last_pop);
        if (lat_chk) check("latency", lat, S);
        pops++;
      end
    end
    prev_stall = out_valid && !out_ready;
    held = {C_out, carry, ovf, zero};
    if (in_valid && in_ready) begin
      exp_q.push_back(model_apply(o, ci, a, b));
      acc_cyc_q.push_back(cyc);
      accepted++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, '0, '0, 1'b1);
  endtask

  // Reset for one edge; optionally offer an accumulate that must be ignored.
  task automatic do_reset(input logic iv_during);
    @(negedge clk);
    rst = 1'b1; in_valid = iv_during; op = 2'b10; A_in = 16'h0077; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    exp_q.delete();
    acc_cyc_q.delete();
    acc_m = '0;
    prev_stall = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_c_out", C_out, 0);
    check("rst_flags", {carry, ovf, zero}, 0);
    check("rst_in_ready", in_ready, 1);
  endtask

  logic [W-1:0] bp_a [5];
  logic [W-1:0] bp_b [5];

  initial begin
    int nb, p0, start, guard;
    rst = 1'b1; in_valid = 1'b0; op = 2'b00; cin = 1'b0; A_in = '0; B_in = '0;
    out_ready = 1'b0; lat_chk = 1'b0; prev_stall = 1'b0; acc_m = '0;
    last_pop = '0; held = '0;
    do_reset(1'b0);

    // Directed arithmetic with exact latency checks.
    lat_chk = 1'b1;
    pops = 0;
    step(1'b1, 2'b00, 1'b1, 16'h1234, 16'h0001, 1'b1);
    idle(4);
    check("add_pulses", pops, 1);
    check("add_lit", last_pop, {16'h1236, 3'b000});

    step(1'b1, 2'b01, 1'b0, 16'h8000, 16'h0001, 1'b1);
    idle(3);
    check("sub_ovf_lit", last_pop, {16'h7FFF, 3'b110});
    step(1'b1, 2'b01, 1'b0, 16'h0000, 16'h0001, 1'b1);
    idle(3);
    check("sub_borrow_lit", last_pop, {16'hFFFF, 3'b000});
    step(1'b1, 2'b00, 1'b0, 16'hFFFF, 16'h0001, 1'b1);
    idle(3);
    check("wrap_lit", last_pop, {16'h0000, 3'b101});

    step(1'b1, 2'b11, 1'b0, 16'h1111, 16'h2222, 1'b1);
    step(1'b1, 2'b10, 1'b1, 16'h7FFF, 16'h0000, 1'b1);
    step(1'b1, 2'b10, 1'b0, 16'h0001, 16'h0000, 1'b1);
    idle(4);
    check("acc_lit", last_pop, {16'h8000, 3'b010});
    lat_chk = 1'b0;

    // Backpressure: five adds offered against a stalled consumer.
    for (int i = 0; i < 5; i++) begin
      bp_a[i] = 16'($urandom);
      bp_b[i] = 16'($urandom);
    end
    start = accepted;
    for (int i = 0; i < 6; i++) begin
      nb = accepted - start;
      step(1'b1, 2'b00, 1'b0, bp_a[nb], bp_b[nb], 1'b0);
    end
    check("bp_accepted", accepted - start, S);
    check("bp_in_ready_full", in_ready, 0);
    p0 = pops;
    for (int i = 0; i < 5; i++) begin
      nb = accepted - start;
      if (nb < 5) step(1'b1, 2'b00, 1'b0, bp_a[nb], bp_b[nb], 1'b1);
      else        step(1'b0, 2'b00, 1'b0, '0, '0, 1'b1);
    end
    check("bp_drain_rate", pops - p0, 5);
    check("bp_all_accepted", accepted - start, 5);
    idle(2);
    check("bp_empty", exp_q.size(), 0);

    // Random mixed traffic with random valid/ready.
    start = accepted;
    guard = 0;
    while (accepted - start < 1000 && guard < 20000) begin
      step(($urandom_range(0, 99) < 70), 2'($urandom), 1'($urandom),
           16'($urandom), 16'($urandom), ($urandom_range(0, 99) < 70));
      guard++;
    end
    check("rand_beats", accepted - start, 1000);
    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      idle(1);
      guard++;
    end
    check("rand_drain", exp_q.size(), 0);

    // Reset with two beats in flight and acc = 0x0042.
    step(1'b1, 2'b11, 1'b0, '0, '0, 1'b1);
    step(1'b1, 2'b10, 1'b0, 16'h0042, '0, 1'b0);
    step(1'b1, 2'b01, 1'b0, 16'h0005, 16'h0003, 1'b0);
    do_reset(1'b1);
    pops = 0;
    idle(4);
    check("rst_no_out", pops, 0);
    step(1'b1, 2'b10, 1'b0, 16'h0005, '0, 1'b1);
    idle(3);
    check("post_rst_acc", last_pop, {16'h0005, 3'b000});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
